// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle shared between the four bus sources and the arbiter.
// The tristate bus y itself is a separate net on the arbiter so that the
// high-Z driver stays on an ordinary module port.
interface tristate_bus_arbiter_if #(
  parameter int DATA_W = 4
);
  logic [3:0]        req;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] d;
  logic [3:0]        grant;
  logic [1:0]        sel;
  logic              busy;
  logic              expired;

  modport master (
    output req, a, b, c, d,
    input  grant, sel, busy, expired
  );

  modport slave (
    input  req, a, b, c, d,
    output grant, sel, busy, expired
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with four sources.
// One owner at a time, one dead cycle between owners, and each tenure is
// capped at MAX_HOLD cycles. All arbiter outputs come from registers, so no
// combinational path exists from req to grant.
module tristate_bus_arbiter #(
  parameter int DATA_W   = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tristate_bus_arbiter_if.slave bus,
  output wire  [DATA_W-1:0]   y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            state_r, state_s;
  logic [7:0]        hold_cnt_r, hold_cnt_s;
  logic [1:0]        last_r, last_s;
  logic [1:0]        sel_r, sel_s;
  logic [3:0]        grant_r, grant_s;
  logic              busy_r, busy_s;
  logic              expired_r, expired_s;
  logic [2:0]        pick_s;
  logic [DATA_W-1:0] mux_s;

  // First requester after 'last' in circular order; bit 2 flags a hit.
  // Scanning from the far end lets the nearest candidate overwrite.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      last_r     <= 2'd3;
      sel_r      <= 2'd0;
      grant_r    <= 4'b0000;
      busy_r     <= 1'b0;
      expired_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      last_r     <= last_s;
      sel_r      <= sel_s;
      grant_r    <= grant_s;
      busy_r     <= busy_s;
      expired_r  <= expired_s;
    end
  end

  // Next-state: arbitrate when the bus is free, police tenure when owned.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    last_s     = last_r;
    sel_s      = sel_r;
    expired_s  = 1'b0;
    pick_s     = rr_pick(bus.req, last_r);
    case (state_r)
      IDLE, TURN: begin
        if (pick_s[2]) begin
          state_s    = GRANT;
          sel_s      = pick_s[1:0];
          last_s     = pick_s[1:0];
          hold_cnt_s = 8'd0;
        end else begin
          state_s    = IDLE;
        end
      end
      GRANT: begin
        hold_cnt_s = hold_cnt_r + 8'd1;
        // A voluntary drop wins over expiry on the same cycle.
        if (!bus.req[sel_r]) begin
          state_s   = TURN;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s   = TURN;
          expired_s = 1'b1;
        end else begin
          state_s   = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, captured by the register above.
  always_comb begin
    if (state_s == GRANT) begin
      grant_s = 4'b0001 << sel_s;
      busy_s  = 1'b1;
    end else begin
      grant_s = 4'b0000;
      busy_s  = 1'b0;
    end
  end

  // Source mux feeding the bus driver.
  always_comb begin
    case (sel_r)
      2'd0:    mux_s = bus.a;
      2'd1:    mux_s = bus.b;
      2'd2:    mux_s = bus.c;
      2'd3:    mux_s = bus.d;
      default: mux_s = bus.a;
    endcase
  end

  assign y           = busy_r ? mux_s : {DATA_W{1'bz}};
  assign bus.grant   = grant_r;
  assign bus.sel     = sel_r;
  assign bus.busy    = busy_r;
  assign bus.expired = expired_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus a random run
// checked against a cycle-level model of owner, tenure length and RR pointer.
module tb_tristate_bus_arbiter;
  localparam int DATA_W   = 4;
  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = 3 * (MAX_HOLD + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.DATA_W(DATA_W)) bus ();
  wire [DATA_W-1:0] y;

  tristate_bus_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .y     (y)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the bus, how many cycles it has driven so far,
  // last winner, last reported sel and whether a forced release just happened.
  int owner_m = -1;
  int held_m  = 0;
  int ptr_m   = 3;
  int sel_m   = 0;
  bit exp_m   = 1'b0;

  task automatic model_reset();
    owner_m = -1; held_m = 0; ptr_m = 3; sel_m = 0; exp_m = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    exp_m = 1'b0;
    if (owner_m >= 0) begin
      if (!r[owner_m]) owner_m = -1;
      else if (held_m == MAX_HOLD) begin owner_m = -1; exp_m = 1'b1; end
      else held_m++;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (owner_m < 0 && r[(ptr_m + k) % 4]) owner_m = (ptr_m + k) % 4;
      end
      if (owner_m >= 0) begin ptr_m = owner_m; sel_m = owner_m; held_m = 1; end
    end
  endtask

  function automatic logic [3:0] exp_grant();
    return (owner_m >= 0) ? 4'(1 << owner_m) : 4'b0000;
  endfunction

  function automatic logic [DATA_W-1:0] exp_y();
    case (owner_m)
      0: return bus.a;
      1: return bus.b;
      2: return bus.c;
      3: return bus.d;
      default: return {DATA_W{1'b0}};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(bus.req);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 4'b1111;
    model_reset();
    #2;
    compared++;
    if ({bus.grant, bus.sel, bus.busy, bus.expired} !== 8'b0000_00_0_0) begin
      mismatched++;
      $display("FAIL reset_outputs: got grant=%b sel=%b busy=%b expired=%b, want 0000 00 0 0",
               bus.grant, bus.sel, bus.busy, bus.expired);
    end
    reset_dut();
  endtask

  task automatic test_single();
    int drv = 0;
    int exp_seen = 0;
    reset_dut();
    bus.a = 4'b1100;
    bus.req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        compared++;
        if (bus.grant !== 4'b0001) begin
          mismatched++;
          $display("FAIL single_latency: got grant=%b, want 0001", bus.grant);
        end
      end
      if (bus.grant === 4'b0001 && y === 4'b1100) drv++;
      if (bus.expired) exp_seen++;
    end
    bus.req = 4'b0000;
    tick();
    if (bus.expired) exp_seen++;
    compared++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_turn: got grant=%b busy=%b, want 0000 0", bus.grant, bus.busy);
    end
    tick();
    if (bus.expired) exp_seen++;
    compared++;
    if (drv != 3 || exp_seen != 0 || bus.grant !== 4'b0000) begin
      mismatched++;
      $display("FAIL single_tenure: got drive_cycles=%0d expired=%0d grant=%b, want 3 0 0000",
               drv, exp_seen, bus.grant);
    end
  endtask

  task automatic test_all_request();
    int starts[$];
    int lens[$];
    int len = 0;
    int pulses = 0;
    logic [3:0] pg;
    reset_dut();
    bus.a = 4'b1100; bus.b = 4'b1010; bus.c = 4'b0011; bus.d = 4'b0110;
    bus.req = 4'b1111;
    for (int k = 0; k < 38; k++) begin
      pg = bus.grant;
      tick();
      compared++;
      if ({bus.grant, bus.sel, bus.busy, bus.expired} !==
          {exp_grant(), 2'(sel_m), owner_m >= 0, exp_m}) begin
        mismatched++;
        $display("FAIL all_req_outs: cycle %0d got grant=%b sel=%0d busy=%b exp=%b, want %b %0d %b %b",
                 k, bus.grant, bus.sel, bus.busy, bus.expired, exp_grant(), sel_m, owner_m >= 0, exp_m);
      end
      if (owner_m >= 0) begin
        compared++;
        if (y !== exp_y()) begin
          mismatched++;
          $display("FAIL all_req_y: cycle %0d got y=%b, want %b", k, y, exp_y());
        end
      end
      if (bus.grant != 4'b0000 && pg == 4'b0000) begin
        for (int i = 0; i < 4; i++) if (bus.grant[i]) starts.push_back(i);
      end
      if (bus.grant != 4'b0000) len++;
      else if (pg != 4'b0000) begin lens.push_back(len); len = 0; end
      if (bus.expired) pulses++;
    end
    compared++;
    if (starts.size() < 5 || starts[0] != 0 || starts[1] != 1 || starts[2] != 2 ||
        starts[3] != 3 || starts[4] != 0) begin
      mismatched++;
      $display("FAIL all_req_order: got %p, want 0 1 2 3 0", starts);
    end
    compared++;
    if (lens.size() != 4 || pulses != 4 || lens[0] != MAX_HOLD || lens[3] != MAX_HOLD) begin
      mismatched++;
      $display("FAIL all_req_tenure: got lens=%p pulses=%0d, want four of %0d and 4 pulses",
               lens, pulses, MAX_HOLD);
    end
  endtask

  task automatic test_rr_wrap();
    int t = 0;
    reset_dut();
    bus.req = 4'b0100;
    tick();
    while (bus.grant !== 4'b0100 && t < 5) begin tick(); t++; end
    compared++;
    if (bus.grant !== 4'b0100) begin
      mismatched++;
      $display("FAIL rr_first_grant: got grant=%b, want 0100", bus.grant);
    end
    repeat (2) tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0101;
    tick();
    compared++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'd0) begin
      mismatched++;
      $display("FAIL rr_wrap: got grant=%b sel=%0d, want 0001 0", bus.grant, bus.sel);
    end
  endtask

  task automatic test_tie();
    int t = 0;
    int early = 0;
    reset_dut();
    bus.req = 4'b0010;
    tick();
    while (bus.grant !== 4'b0010 && t < 5) begin tick(); t++; end
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      tick();
      if (bus.grant !== 4'b0010 || bus.expired) early++;
    end
    compared++;
    if (early != 0) begin
      mismatched++;
      $display("FAIL tie_hold: got %0d bad cycles before the 8th, want 0", early);
    end
    bus.req = 4'b0101;
    tick();
    compared++;
    if (bus.grant !== 4'b0000 || bus.expired !== 1'b0) begin
      mismatched++;
      $display("FAIL tie_turn: got grant=%b expired=%b, want 0000 0", bus.grant, bus.expired);
    end
    tick();
    compared++;
    if (bus.grant !== 4'b0100) begin
      mismatched++;
      $display("FAIL tie_next: got grant=%b, want 0100", bus.grant);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    bus.b = 4'b1001;
    bus.req = 4'b0010;
    tick();
    tick();
    compared++;
    if (bus.grant !== 4'b0010 || y !== 4'b1001) begin
      mismatched++;
      $display("FAIL async_pre: got grant=%b y=%b, want 0010 1001", bus.grant, y);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'd0) begin
      mismatched++;
      $display("FAIL async_release: got grant=%b busy=%b sel=%0d, want 0000 0 0",
               bus.grant, bus.busy, bus.sel);
    end
    #2;
    rst_n = 1'b1;
    bus.req = 4'b1000;
    tick();
    compared++;
    if (bus.grant !== 4'b1000 || bus.sel !== 2'd3) begin
      mismatched++;
      $display("FAIL async_regrant: got grant=%b sel=%0d, want 1000 3", bus.grant, bus.sel);
    end
  endtask

  task automatic test_random();
    int wcnt[4] = '{0, 0, 0, 0};
    int maxw = 0;
    logic [3:0] r;
    logic [3:0] pg;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.a = 4'($urandom); bus.b = 4'($urandom);
      bus.c = 4'($urandom); bus.d = 4'($urandom);
      r = bus.req;
      pg = bus.grant;
      tick();
      compared++;
      if ({bus.grant, bus.sel, bus.busy, bus.expired} !==
          {exp_grant(), 2'(sel_m), owner_m >= 0, exp_m} || !$onehot0(bus.grant)) begin
        mismatched++;
        $display("FAIL rand_outs: cycle %0d got grant=%b sel=%0d busy=%b exp=%b, want %b %0d %b %b",
                 k, bus.grant, bus.sel, bus.busy, bus.expired, exp_grant(), sel_m, owner_m >= 0, exp_m);
      end
      if (bus.grant !== 4'b0000) begin
        compared++;
        if (y !== exp_y()) begin
          mismatched++;
          $display("FAIL rand_y: cycle %0d got y=%b, want %b", k, y, exp_y());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.grant[i] || !r[i] || pg[i]) wcnt[i] = 0;
        else wcnt[i]++;
        if (wcnt[i] > maxw) maxw = wcnt[i];
      end
    end
    compared++;
    if (maxw > WAIT_MAX) begin
      mismatched++;
      $display("FAIL rand_starvation: got max wait %0d cycles, want <= %0d", maxw, WAIT_MAX);
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    test_reset();
    test_single();
    test_all_request();
    test_rr_wrap();
    test_tie();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
